// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the Coprocessor-0 unit and its neighbours (NPC,
// hazard unit): CP0 register numbers, SR/Cause field positions, exception
// codes and the exception handler entry address.
// No ports (package).
// -----------------------------------------------------------------------------
package cp0_pkg;

    typedef enum logic [4:0] {
        REG_SR    = 5'd12,
        REG_CAUSE = 5'd13,
        REG_EPC   = 5'd14,
        REG_PRID  = 5'd15
    } cp0_reg_e;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    // SR fields
    localparam int unsigned SR_IM_HI     = 15;
    localparam int unsigned SR_IM_LO     = 10;
    localparam int unsigned SR_EXL       = 1;
    localparam int unsigned SR_IE        = 0;

    // Cause fields
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_EXC_LO = 2;

    // Exception/interrupt handler entry point, consumed by NPC
    localparam logic [31:0] HANDLER_ENTRY = 32'h0000_4180;

    // EPC to record for a faulting/interrupted instruction: a delay-slot
    // instruction restarts at its branch (modulo 2^32).
    function automatic logic [31:0] epc_of(input logic [31:0] vpc, input logic bd);
        return bd ? (vpc - 32'd4) : vpc;
    endfunction

endpackage

// File: rtl/cp0_if.sv
// -----------------------------------------------------------------------------
// cp0_if
// M-stage bus between the pipeline and CP0.
//   pipeline -> CP0 : A1 (mfc0 reg), A2 (mtc0 reg), DIn, WE, EXLClr (eret),
//                     VPC, BDIn, ExcCodeIn, HWInt
//   CP0 -> pipeline : Req (flush + redirect), EPCOut (eret target), DOut
// Modports: master = pipeline side, slave = CP0 side.
// -----------------------------------------------------------------------------
interface cp0_if;

    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic        EXLClr;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    modport master (
        output A1, A2, DIn, WE, EXLClr, VPC, BDIn, ExcCodeIn, HWInt,
        input  Req, EPCOut, DOut
    );

    modport slave (
        input  A1, A2, DIn, WE, EXLClr, VPC, BDIn, ExcCodeIn, HWInt,
        output Req, EPCOut, DOut
    );

endinterface

// File: rtl/cp0.sv
// -----------------------------------------------------------------------------
// cp0
// Coprocessor-0 status/exception unit at the M stage. Holds SR, Cause, EPC
// and PRId, merges level-sensitive hardware interrupts with the M-stage
// exception code and raises Req (combinational) to flush the pipeline and
// redirect fetch. Services mtc0 (SR, EPC), mfc0 and eret.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : cp0_if.slave (see cp0_if for the signal list)
// Parameter:
//   PRID  : value read back from register 15
// -----------------------------------------------------------------------------
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_7007
) (
    input  logic  clk,
    input  logic  reset,
    cp0_if.slave  bus
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_take;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    assign w_int_req = (|(bus.HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (bus.ExcCodeIn != 5'd0) & ~r_exl;
    assign w_take    = w_int_req | w_exc_req;
    assign bus.Req   = ~reset & w_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= bus.HWInt;
            if (w_take) begin
                // Exception entry: mtc0/eret in the same cycle are dropped.
                r_exl     <= 1'b1;
                r_exccode <= w_int_req ? EXC_INT : bus.ExcCodeIn;
                r_bd      <= bus.BDIn;
                r_epc     <= epc_of(bus.VPC, bus.BDIn);
            end else begin
                if (bus.WE && bus.A2 == REG_SR) begin
                    r_im  <= bus.DIn[SR_IM_HI:SR_IM_LO];
                    r_exl <= bus.DIn[SR_EXL];
                    r_ie  <= bus.DIn[SR_IE];
                end
                if (bus.WE && bus.A2 == REG_EPC) begin
                    r_epc <= bus.DIn;
                end
                // Placed after the SR write so eret wins for EXL.
                if (bus.EXLClr) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_sr                        = '0;
        w_sr[SR_IM_HI:SR_IM_LO]     = r_im;
        w_sr[SR_EXL]                = r_exl;
        w_sr[SR_IE]                 = r_ie;
        w_cause                     = '0;
        w_cause[CAUSE_BD]           = r_bd;
        w_cause[CAUSE_IP_HI:CAUSE_IP_LO]   = r_ip;
        w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = r_exccode;
    end

    // Outputs are forced to zero while reset is held so they are defined
    // before the first reset edge has loaded the registers.
    always_comb begin
        bus.DOut = '0;
        case (bus.A1)
            REG_SR:    bus.DOut = reset ? '0 : w_sr;
            REG_CAUSE: bus.DOut = reset ? '0 : w_cause;
            REG_EPC:   bus.DOut = reset ? '0 : r_epc;
            REG_PRID:  bus.DOut = PRID;
            default:   bus.DOut = '0;
        endcase
    end

    assign bus.EPCOut = reset ? '0 : r_epc;

endmodule
